// File: rtl/coeff_to_three_bytes_packer_pkg.sv
// Shared constants and types for the coefficient-to-bytes packer.
// Q, N_COEFF and COEFF_W match the sampler so the two blocks round-trip.
package coeff_to_three_bytes_packer_pkg;

  localparam int          N_COEFF_DEF = 256;
  localparam logic [23:0] Q_DEF       = 24'd8380417;
  localparam int          COEFF_W     = 23;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  // MSB-first byte select from the 24-bit b0b1b2 word.
  function automatic logic [7:0] word_byte(
    input logic [23:0] w,
    input logic [1:0]  i
  );
    logic [7:0] b;
    b = 8'h00;
    unique case (1'b1)
      (i == 2'd0): b = w[23:16];
      (i == 2'd1): b = w[15:8];
      (i == 2'd2): b = w[7:0];
      default:     b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/coeff_to_three_bytes_packer_range_chk.sv
// Combinational range check: oor = coeff >= Q.
// Ports: coeff (24b) in, oor out.
module coeff_range_chk
  import coeff_to_three_bytes_packer_pkg::*;
#(
  parameter logic [23:0] Q = Q_DEF
) (
  input  logic [23:0] coeff,
  output logic        oor
);

  assign oor = (coeff >= Q);

endmodule

// File: rtl/coeff_to_three_bytes_packer.sv
// Packs 23-bit coefficients into 3 MSB-first bytes, 1 byte/cycle.
// Ports: coeff valid/ready in, byte valid/ready out, byte_last, range_err, busy.
module coeff_to_three_bytes_packer
  import coeff_to_three_bytes_packer_pkg::*;
#(
  parameter int          N_COEFF = N_COEFF_DEF,
  parameter logic [23:0] Q       = Q_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        coeff_valid,
  output logic        coeff_ready,
  input  logic [23:0] coeff,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic [7:0]  byte_out,
  output logic        byte_last,
  output logic        range_err,
  input  logic        err_clr,
  output logic        busy
);

  localparam int CW = (N_COEFF > 1) ? $clog2(N_COEFF) : 1;

  state_e        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [23:0]   hold_q, hold_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  logic send, last_b, xfer, accept, oor, at_end;

  coeff_range_chk #(
    .Q (Q)
  ) u_chk (
    .coeff (coeff),
    .oor   (oor)
  );

  assign send   = (state_q == SEND);
  assign last_b = send && (idx_q == 2'd2);
  assign xfer   = send && byte_ready;
  assign at_end = (cnt_q == CW'(N_COEFF - 1));

  // Ready while the final byte drains, so the next word
  // loads in the same cycle and the stream has no gap.
  assign coeff_ready = !rst && (!send || (last_b && byte_ready));
  assign accept      = coeff_valid && coeff_ready;

  assign byte_valid = send;
  assign byte_out   = send ? word_byte(hold_q, idx_q) : 8'h00;
  assign byte_last  = last_b && at_end;
  assign range_err  = err_q;
  assign busy       = send;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    if (xfer) begin
      if (idx_q == 2'd2) begin
        state_d = IDLE;
        idx_d   = 2'd0;
        cnt_d   = at_end ? '0 : cnt_q + CW'(1);
      end else begin
        idx_d = idx_q + 2'd1;
      end
    end
    if (accept) begin
      state_d = SEND;
      idx_d   = 2'd0;
      hold_d  = {1'b0, coeff[COEFF_W-1:0]};
    end
    // A new error outranks a clear in the same cycle.
    if (accept && oor) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      hold_q  <= 24'h0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_coeff_to_three_bytes_packer.sv
// Directed self-checking bench for coeff_to_three_bytes_packer.
// Inputs change on negedge; outputs sampled 1ns later.
module tb_coeff_to_three_bytes_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        coeff_valid = 1'b0;
  logic        coeff_ready;
  logic [23:0] coeff = 24'h0;
  logic        byte_valid;
  logic        byte_ready = 1'b1;
  logic [7:0]  byte_out;
  logic        byte_last;
  logic        range_err;
  logic        err_clr = 1'b0;
  logic        busy;

  int errors = 0;
  int checks = 0;

  logic [23:0] src [0:1023];

  always #5 clk = ~clk;

  coeff_to_three_bytes_packer dut (
    .clk         (clk),
    .rst         (rst),
    .coeff_valid (coeff_valid),
    .coeff_ready (coeff_ready),
    .coeff       (coeff),
    .byte_valid  (byte_valid),
    .byte_ready  (byte_ready),
    .byte_out    (byte_out),
    .byte_last   (byte_last),
    .range_err   (range_err),
    .err_clr     (err_clr),
    .busy        (busy)
  );

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    coeff_valid = 1'b0;
    err_clr = 1'b0;
    byte_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (byte_valid !== 1'b0 || byte_out !== 8'h00 ||
        byte_last !== 1'b0 || range_err !== 1'b0 ||
        busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_vals: got v=%b b=%h l=%b e=%b busy=%b want 0",
               byte_valid, byte_out, byte_last, range_err, busy);
    end
    checks++;
    if (coeff_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: got %b want 0", coeff_ready);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (coeff_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_ready: got %b want 1", coeff_ready);
    end
  endtask

  task automatic test_single();
    logic [7:0] exp [3];
    exp[0] = 8'h12; exp[1] = 8'h34; exp[2] = 8'h56;
    do_reset();
    @(negedge clk);
    coeff_valid = 1'b1;
    coeff = 24'h123456;
    byte_ready = 1'b1;
    #1;
    checks++;
    if (coeff_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_accept: got rdy=%b busy=%b want 1/0",
               coeff_ready, busy);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      coeff_valid = 1'b0;
      #1;
      checks++;
      if (byte_valid !== 1'b1 || byte_out !== exp[k] ||
          byte_last !== 1'b0) begin
        errors++;
        $display("FAIL single_byte%0d: got v=%b b=%h l=%b want 1 %h 0",
                 k, byte_valid, byte_out, byte_last, exp[k]);
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || byte_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_done: got busy=%b v=%b want 0", busy, byte_valid);
    end
  endtask

  // Streams src[0..n-1]; stops early once stop_at bytes are counted.
  task automatic run_stream(input int n, input bit rnd,
                            input int stop_at, input string tag);
    int qi = 0;
    int bi = 0;
    int cyc = 0;
    int first = -1;
    int lastc = 0;
    int total = 3 * n;
    logic pv = 1'b0;
    logic pr = 1'b0;
    logic pl = 1'b0;
    logic [7:0] pb = 8'h00;
    logic [23:0] w;
    logic [7:0] eb;
    logic el;
    while (bi < total && bi != stop_at && cyc < 20 * total + 100) begin
      @(negedge clk);
      coeff_valid = (qi < n);
      coeff = (qi < n) ? src[qi] : 24'h0;
      byte_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (pv && !pr) begin
        checks++;
        if (byte_valid !== 1'b1 || byte_out !== pb || byte_last !== pl) begin
          errors++;
          $display("FAIL %s_stall@%0d: got v=%b b=%h l=%b want 1 %h %b",
                   tag, bi, byte_valid, byte_out, byte_last, pb, pl);
        end
      end
      if (byte_valid && byte_ready) begin
        w = {1'b0, src[bi / 3][22:0]};
        eb = (bi % 3 == 0) ? w[23:16] :
             (bi % 3 == 1) ? w[15:8] : w[7:0];
        el = ((bi % 768) == 767);
        checks++;
        if (byte_out !== eb || byte_last !== el) begin
          errors++;
          $display("FAIL %s_byte%0d: got b=%h l=%b want %h %b",
                   tag, bi, byte_out, byte_last, eb, el);
        end
        if (first < 0) first = cyc;
        lastc = cyc;
        bi++;
      end
      if (coeff_valid && coeff_ready) qi++;
      pv = byte_valid;
      pr = byte_ready;
      pb = byte_out;
      pl = byte_last;
      cyc++;
    end
    checks++;
    if (bi != total && bi != stop_at) begin
      errors++;
      $display("FAIL %s_timeout: got %0d bytes want %0d", tag, bi, total);
    end
    if (!rnd && stop_at < 0) begin
      checks++;
      if (lastc - first != total - 1) begin
        errors++;
        $display("FAIL %s_gapfree: got span %0d want %0d",
                 tag, lastc - first + 1, total);
      end
    end
    @(negedge clk);
    coeff_valid = 1'b0;
    byte_ready = 1'b1;
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 512; i++) src[i] = 24'(i);
    run_stream(512, 1'b0, -1, "b2b");
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < 60; i++) src[i] = 24'($urandom_range(0, 8380416));
    run_stream(60, 1'b1, -1, "bp");
  endtask

  task automatic test_range();
    logic [23:0] cv [3];
    logic        cl [3];
    logic [23:0] ew [3];
    logic        ee [3];
    logic [7:0]  b [3];
    cv[0] = 24'h7FE001; cl[0] = 1'b0; ew[0] = 24'h7FE001; ee[0] = 1'b1;
    cv[1] = 24'h7FE000; cl[1] = 1'b0; ew[1] = 24'h7FE000; ee[1] = 1'b0;
    cv[2] = 24'hFFFFFF; cl[2] = 1'b1; ew[2] = 24'h7FFFFF; ee[2] = 1'b1;
    do_reset();
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      coeff_valid = 1'b1;
      coeff = cv[t];
      err_clr = cl[t];
      #1;
      checks++;
      if (range_err !== 1'b0 || coeff_ready !== 1'b1) begin
        errors++;
        $display("FAIL range%0d_pre: got err=%b rdy=%b want 0 1",
                 t, range_err, coeff_ready);
      end
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        coeff_valid = 1'b0;
        err_clr = 1'b0;
        #1;
        b[k] = byte_out;
        checks++;
        if (range_err !== ee[t]) begin
          errors++;
          $display("FAIL range%0d_err%0d: got %b want %b",
                   t, k, range_err, ee[t]);
        end
      end
      checks++;
      if ({b[0], b[1], b[2]} !== ew[t]) begin
        errors++;
        $display("FAIL range%0d_bytes: got %h want %h",
                 t, {b[0], b[1], b[2]}, ew[t]);
      end
      @(negedge clk);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      #1;
      checks++;
      if (range_err !== 1'b0) begin
        errors++;
        $display("FAIL range%0d_clr: got %b want 0", t, range_err);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 256; i++) src[i] = 24'(i * 32749);
    src[3] = 24'hFFFFFF;
    run_stream(256, 1'b0, 29, "mid");
    checks++;
    if (range_err !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre: got err=%b busy=%b want 1 1", range_err, busy);
    end
    rst = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (byte_valid !== 1'b0 || byte_out !== 8'h00 ||
        byte_last !== 1'b0 || range_err !== 1'b0 ||
        busy !== 1'b0 || coeff_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got v=%b b=%h l=%b e=%b busy=%b rdy=%b want 0",
               byte_valid, byte_out, byte_last, range_err, busy, coeff_ready);
    end
    rst = 1'b0;
    for (int i = 0; i < 256; i++) src[i] = 24'(8380416 - i);
    run_stream(256, 1'b0, -1, "post");
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_range();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
